gost89_cfb_encrypt: RTL and testbench

//  GOST 28147-89 cipher-feedback (CFB) encryptor, one 64-bit block per request.

---
 rtl/gost89_cfb_encrypt.sv | 106 ++++++++++
 tb/tb_gost89_cfb_encrypt.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gost89_cfb_encrypt.sv
// ============================================================================
// Module      : gost89_cfb_encrypt
// Description : GOST 28147-89 CFB encryptor, one 64-bit block per request,
//               iterative core running one Feistel round per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gost89_cfb_encrypt #(
    parameter logic [511:0] SBOX = 512'h4a92d80e6b1c7f53eb4c6dfa23810759581da342efc7609b7da1089fe46cb2536c715fd84a9e03b24ba0721d36859cfedb413f590ae7682c1fd057a4923e6b8c
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_data,
    input  logic         load_IV,
    input  logic [255:0] key,
    input  logic [63:0]  in,
    input  logic [63:0]  IV,
    output logic [63:0]  out,
    output logic         out_valid,
    output logic         busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] n1_q;
    logic [31:0] n2_q;
    logic [63:0] in_q;
    logic [63:0] fb_q;
    logic [63:0] out_q;
    logic        out_valid_q;

    logic [2:0]  w_kidx;
    logic [7:0]  w_kbase;
    logic [31:0] w_kword;
    logic [31:0] w_sum;
    logic [31:0] w_sub;
    logic [31:0] w_rol;
    logic [31:0] n1_d;
    logic [31:0] n2_d;
    logic [63:0] w_cipher;

    // Rounds 24..31 walk the key words backwards: 31-r == ~r[2:0] there.
    assign w_kidx  = (cnt_q[4:3] == 2'b11) ? ~cnt_q[2:0] : cnt_q[2:0];
    assign w_kbase = {3'd7 - w_kidx, 5'd0};
    assign w_kword = key[w_kbase +: 32];
    assign w_sum   = n1_q + w_kword;

    for (genvar gi = 0; gi < 8; gi++) begin : g_sbox
        assign w_sub[4*gi +: 4] = SBOX[{3'(gi), w_sum[4*gi +: 4], 2'b00} +: 4];
    end

    assign w_rol    = {w_sub[20:0], w_sub[31:21]};
    assign n1_d     = n2_q ^ w_rol;
    assign n2_d     = n1_q;
    assign w_cipher = in_q ^ {n2_d, n1_d};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 6'd0;
            n1_q        <= 32'd0;
            n2_q        <= 32'd0;
            in_q        <= 64'd0;
            fb_q        <= 64'd0;
            out_q       <= 64'd0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_data) begin
                        in_q         <= in;
                        {n1_q, n2_q} <= load_IV ? IV : fb_q;
                        cnt_q        <= 6'd0;
                        state_q      <= S_RUN;
                    end
                end
                S_RUN: begin
                    n1_q  <= n1_d;
                    n2_q  <= n2_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        out_q       <= w_cipher;
                        fb_q        <= w_cipher;
                        out_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_gost89_cfb_encrypt.sv
// ============================================================================
// Module      : tb_gost89_cfb_encrypt
// Description : Self-checking bench for gost89_cfb_encrypt against a
//               behavioural GOST 28147-89 / CFB model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gost89_cfb_encrypt;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         load_r;
    logic         liv_r;
    logic [255:0] key_r;
    logic [63:0]  in_r;
    logic [63:0]  iv_r;
    logic [63:0]  out;
    logic         out_valid;
    logic         busy;

    int nchk = 0;
    int nerr = 0;

    logic [511:0] sbox_v = 512'h4a92d80e6b1c7f53eb4c6dfa23810759581da342efc7609b7da1089fe46cb2536c715fd84a9e03b24ba0721d36859cfedb413f590ae7682c1fd057a4923e6b8c;

    gost89_cfb_encrypt dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_data (load_r),
        .load_IV   (liv_r),
        .key       (key_r),
        .in        (in_r),
        .IV        (iv_r),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
        $fatal(1);
    end

    function automatic logic [63:0] gost_e(input logic [255:0] k, input logic [63:0] blk);
        logic [31:0] a, b, t, s, ki;
        int idx;
        a = blk[63:32];
        b = blk[31:0];
        for (int r = 0; r < 32; r++) begin
            idx = (r < 24) ? (r % 8) : (31 - r);
            ki  = k[255 - 32*idx -: 32];
            t   = a + ki;
            for (int i = 0; i < 8; i++)
                s[4*i +: 4] = sbox_v[64*i + 4*int'(t[4*i +: 4]) +: 4];
            s = (s << 11) | (s >> 21);
            t = b ^ s;
            b = a;
            a = t;
        end
        return {b, a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_block(input logic [255:0] k, input logic [63:0] pt, input logic [63:0] iv,
                            input logic liv, input logic [63:0] exp, input string nm,
                            output logic [63:0] obs);
        int n;
        @(negedge clk);
        key_r = k; in_r = pt; iv_r = iv; liv_r = liv; load_r = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_busy_start"}, 64'(busy), 64'd1);
        @(negedge clk);
        load_r = 1'b0; in_r = ~pt; iv_r = ~iv; liv_r = ~liv;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 40);
        chk({nm, "_latency"}, 64'(n), 64'd32);
        chk({nm, "_out"}, out, exp);
        chk({nm, "_busy_done"}, 64'(busy), 64'd0);
        obs = out;
        @(posedge clk); #1;
        chk({nm, "_valid_pulse"}, 64'(out_valid), 64'd0);
        chk({nm, "_out_hold"}, out, exp);
    endtask

    typedef struct {
        logic [255:0] k;
        logic [63:0]  pt;
        logic [63:0]  iv;
        logic         liv;
        logic [63:0]  exp;
    } vec_t;

    localparam int NV = 7;
    vec_t        tbl [NV];
    logic [63:0] obs [NV];

    initial begin
        logic [255:0] ka, ksw, kc;
        logic [63:0]  fb_m, o, e1, e2, rec, ofb;

        ka  = 256'h00010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F;
        ksw = 256'h1C1D1E1F_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_00010203;
        kc  = 256'h243F6A88_85A308D3_13198A2E_03707344_A4093822_299F31D0_082EFA98_EC4E6C89;

        tbl[0] = '{256'd0, 64'd0, 64'd0, 1'b1, 64'd0};
        tbl[1] = '{256'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0};
        tbl[2] = '{kc, 64'h1111_2222_3333_4444, 64'h0123_4567_89AB_CDEF, 1'b1, 64'd0};
        tbl[3] = '{kc, 64'hCAFE_BABE_DEAD_BEEF, 64'h5555_5555_5555_5555, 1'b0, 64'd0};
        tbl[4] = '{kc, 64'h0000_0000_0000_0000, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'd0};
        tbl[5] = '{ka, 64'd0, 64'hFEDC_BA98_7654_3210, 1'b1, 64'd0};
        tbl[6] = '{ksw, 64'd0, 64'hFEDC_BA98_7654_3210, 1'b1, 64'd0};
        fb_m = 64'd0;
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].liv) fb_m = tbl[i].iv;
            tbl[i].exp = tbl[i].pt ^ gost_e(tbl[i].k, fb_m);
            fb_m = tbl[i].exp;
        end

        reset_n = 1'b0; load_r = 1'b0; liv_r = 1'b0;
        key_r = '0; in_r = '0; iv_r = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_out", out, 64'd0);
        @(negedge clk); reset_n = 1'b1;

        for (int i = 0; i < NV; i++)
            do_block(tbl[i].k, tbl[i].pt, tbl[i].iv, tbl[i].liv, tbl[i].exp, $sformatf("vec%0d", i), obs[i]);

        chk("gamma_indep_of_in", obs[1], ~obs[0]);
        ofb = 64'd0;
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].liv) ofb = tbl[i].iv;
            rec = obs[i] ^ gost_e(tbl[i].k, ofb);
            chk($sformatf("decrypt%0d", i), rec, tbl[i].pt);
            ofb = obs[i];
        end
        nchk++;
        if (obs[5] === obs[6]) begin
            nerr++;
            $display("FAIL key_swap: got %h expected a value different from %h", obs[6], obs[5]);
        end

        // Loads at E5 and E32 must be dropped; the one held through E33 is taken.
        e1 = 64'h0F0F_0F0F_F0F0_F0F0 ^ gost_e(kc, 64'h1357_9BDF_2468_ACE0);
        e2 = 64'h7777_8888_9999_0000 ^ gost_e(kc, e1);
        begin
            int nv;
            nv = 0;
            @(negedge clk);
            key_r = kc; in_r = 64'h0F0F_0F0F_F0F0_F0F0; iv_r = 64'h1357_9BDF_2468_ACE0;
            liv_r = 1'b1; load_r = 1'b1;
            @(posedge clk); #1;
            for (int e = 1; e <= 66; e++) begin
                @(negedge clk);
                load_r = (e == 5) || (e == 32) || (e == 33);
                if (e == 5) begin in_r = 64'hDEAD_DEAD_DEAD_DEAD; iv_r = 64'hBAD0_BAD0_BAD0_BAD0; liv_r = 1'b1; end
                if (e == 32) begin in_r = 64'h7777_8888_9999_0000; iv_r = 64'hBAD1_BAD1_BAD1_BAD1; liv_r = 1'b0; end
                @(posedge clk); #1;
                if (out_valid) nv++;
                if (e == 5)  chk("ign_busy_e5", 64'(busy), 64'd1);
                if (e == 32) begin
                    chk("ign_valid_e32", 64'(out_valid), 64'd1);
                    chk("ign_out_e32", out, e1);
                end
                if (e == 33) begin
                    chk("ign_valid_e33", 64'(out_valid), 64'd0);
                    chk("accept_busy_e33", 64'(busy), 64'd1);
                end
                if (e == 65) begin
                    chk("accept_valid_e65", 64'(out_valid), 64'd1);
                    chk("accept_out_e65", out, e2);
                end
            end
            load_r = 1'b0;
            chk("valid_count", 64'(nv), 64'd2);
        end

        // Asynchronous reset mid-run, then fb must be back to zero.
        @(negedge clk);
        key_r = kc; in_r = 64'h1234; iv_r = 64'h5678; liv_r = 1'b1; load_r = 1'b1;
        @(posedge clk);
        @(negedge clk); load_r = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_out", out, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        o = 64'hA5A5_5A5A_0F0F_F0F0;
        do_block(ka, o, 64'hFFFF_0000_FFFF_0000, 1'b0, o ^ gost_e(ka, 64'd0), "postrst_fb0", rec);
        do_block(ka, o, 64'hFEDC_BA98_7654_3210, 1'b1, o ^ gost_e(ka, 64'hFEDC_BA98_7654_3210), "postrst_iv", rec);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire
